// File: rtl/bbc_mbox_pkg.sv
// rtl/bbc_mbox_pkg.sv - register map, bit indices and depth check for the BBC host mailbox
package bbc_mbox_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_TXCNT  = 2'd3
  } reg_off_e;

  localparam int ST_TX_NE   = 7;
  localparam int ST_RX_FULL = 6;
  localparam int ST_TX_UNF  = 5;
  localparam int ST_RX_OVF  = 4;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  function automatic bit depth_ok(input int unsigned d);
    return (d == 2) || (d == 4) || (d == 8);
  endfunction

endpackage

// File: rtl/sync_fifo_m.sv
// rtl/sync_fifo_m.sv - single-clock FIFO with wrap-bit pointers, flush and occupancy count
module sync_fifo_m #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [3:0]       count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      diff;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

  // flush wins over any push/pop presented in the same cycle
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];
  assign diff  = wptr - rptr;
  assign count = 4'(diff);

endmodule

// File: rtl/bbc_mailbox_m.sv
// rtl/bbc_mailbox_m.sv - BBC FRED-space byte mailbox: host latches, phi2 sync, register file, RX/TX FIFOs
module bbc_mailbox_m
  import bbc_mbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADR = 16'hFC40,
  parameter int          DEPTH    = 8
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        bbc_phi2,
  input  logic [15:0] bbc_adr,
  input  logic        bbc_rnw,
  inout  wire  [7:0]  bbc_data,
  inout  wire         irqb,
  output logic [7:0]  rx_dat,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [7:0]  tx_dat,
  input  logic        tx_valid,
  output logic        tx_ready
);

  // an illegal DEPTH collapses to 0, which cannot elaborate a FIFO
  localparam int FIFO_DEPTH = depth_ok(DEPTH) ? DEPTH : 0;

  logic       sel;
  reg_off_e   off;
  logic       lat_sel;
  logic       lat_rnw;
  reg_off_e   lat_off;
  logic [7:0] lat_data;

  logic       phi2_s1;
  logic       phi2_s2;
  logic       phi2_s3;
  logic       armed;
  logic       host_ev;

  logic       ev_acc;
  logic       ev_wr_data;
  logic       ev_rd_data;
  logic       ev_rd_stat;
  logic       ev_wr_ctrl;
  logic       flush;

  logic       unf;
  logic       ovf;
  logic       irq_en;

  logic [7:0] tx_head;
  logic [3:0] tx_count;
  logic       tx_full;
  logic       tx_empty;
  logic [3:0] rx_count;
  logic       rx_full;
  logic       rx_empty;

  logic [7:0] status;
  logic [7:0] rd_mux;

  assign sel = (bbc_adr[15:2] == BASE_ADR[15:2]);
  assign off = reg_off_e'(bbc_adr[1:0]);

  // host-side capture; holds from phi2 fall until the next phi2 rise
  always_latch begin
    if (!resetb) begin
      lat_sel  <= 1'b0;
      lat_rnw  <= 1'b1;
      lat_off  <= REG_DATA;
      lat_data <= 8'h00;
    end else if (bbc_phi2) begin
      lat_sel  <= sel;
      lat_rnw  <= bbc_rnw;
      lat_off  <= off;
      lat_data <= bbc_data;
    end
  end

  // Sync chain resets high and armed stays low until a real phi2 low is seen,
  // so a host cycle cut by reset never produces an event afterwards.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      phi2_s1 <= 1'b1;
      phi2_s2 <= 1'b1;
      phi2_s3 <= 1'b1;
      armed   <= 1'b0;
    end else begin
      phi2_s1 <= bbc_phi2;
      phi2_s2 <= phi2_s1;
      phi2_s3 <= phi2_s2;
      armed   <= armed | ~phi2_s2;
    end
  end

  assign host_ev = phi2_s3 & ~phi2_s2 & armed;

  assign ev_acc     = host_ev & lat_sel;
  assign ev_wr_data = ev_acc & ~lat_rnw & (lat_off == REG_DATA);
  assign ev_rd_data = ev_acc &  lat_rnw & (lat_off == REG_DATA);
  assign ev_rd_stat = ev_acc &  lat_rnw & (lat_off == REG_STATUS);
  assign ev_wr_ctrl = ev_acc & ~lat_rnw & (lat_off == REG_CTRL);
  assign flush      = ev_wr_ctrl & lat_data[CTRL_FLUSH];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      unf    <= 1'b0;
      ovf    <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      if (ev_rd_stat || flush) begin
        unf <= 1'b0;
        ovf <= 1'b0;
      end else begin
        if (ev_rd_data && tx_empty) unf <= 1'b1;
        if (ev_wr_data && rx_full)  ovf <= 1'b1;
      end
      if (ev_wr_ctrl) irq_en <= lat_data[CTRL_IRQ_EN];
    end
  end

  sync_fifo_m #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .resetb (resetb),
    .push   (ev_wr_data),
    .pop    (rx_ready),
    .flush  (flush),
    .din    (lat_data),
    .dout   (rx_dat),
    .count  (rx_count),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  sync_fifo_m #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .resetb (resetb),
    .push   (tx_valid),
    .pop    (ev_rd_data),
    .flush  (flush),
    .din    (tx_dat),
    .dout   (tx_head),
    .count  (tx_count),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  assign rx_valid = ~rx_empty;
  assign tx_ready = ~tx_full;

  always_comb begin
    status             = 8'h00;
    status[ST_TX_NE]   = ~tx_empty;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_UNF]  = unf;
    status[ST_RX_OVF]  = ovf;
    status[3:0]        = rx_count;
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (off)
      REG_DATA:   rd_mux = tx_head;
      REG_STATUS: rd_mux = status;
      REG_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
      REG_TXCNT:  rd_mux = {4'h0, tx_count};
      default:    rd_mux = 8'h00;
    endcase
  end

  assign bbc_data = (resetb & bbc_phi2 & sel & bbc_rnw) ? rd_mux : 8'bz;
  assign irqb     = (irq_en & ~tx_empty) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_bbc_mailbox_m.sv
// tb/tb_bbc_mailbox_m.sv - self-checking bench for bbc_mailbox_m: vector table, corner sequences, random vs queue model
module tb_bbc_mailbox_m;

  localparam logic [15:0] BASE  = 16'hFC40;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetb;
  logic        bbc_phi2;
  logic [15:0] bbc_adr;
  logic        bbc_rnw;
  tri1  [7:0]  bbc_data;
  tri1         irqb;
  logic [7:0]  rx_dat;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_dat;
  logic        tx_valid;
  logic        tx_ready;

  logic        host_drv;
  logic [7:0]  host_wd;

  int vectors = 0;
  int miscompares = 0;

  assign bbc_data = host_drv ? host_wd : 8'bz;

  always #20 clk = ~clk;

  bbc_mailbox_m #(.BASE_ADR(BASE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .resetb   (resetb),
    .bbc_phi2 (bbc_phi2),
    .bbc_adr  (bbc_adr),
    .bbc_rnw  (bbc_rnw),
    .bbc_data (bbc_data),
    .irqb     (irqb),
    .rx_dat   (rx_dat),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_dat   (tx_dat),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  typedef struct {
    logic       rnw;
    logic [1:0] off;
    logic [7:0] wd;
    logic [7:0] rd;
    logic       rxv;
    logic [7:0] rxd;
    logic       irq;
  } vec_t;

  vec_t tbl [12];

  // reference model: plain queues and flags
  logic [7:0] m_rx [$];
  logic [7:0] m_tx [$];
  bit         m_unf;
  bit         m_ovf;
  bit         m_irq;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic host_cycle(input logic rnw, input logic [1:0] off, input logic [7:0] wd,
                            input bit race, input logic [7:0] race_byte, output logic [7:0] rd);
    bbc_adr  = BASE | {14'd0, off};
    bbc_rnw  = rnw;
    host_wd  = wd;
    host_drv = ~rnw;
    repeat (8) @(negedge clk);
    bbc_phi2 = 1'b1;
    repeat (5) @(negedge clk);
    rd = bbc_data;
    @(negedge clk);
    bbc_phi2 = 1'b0;
    @(negedge clk);
    host_drv = 1'b0;
    bbc_rnw  = 1'b1;
    bbc_adr  = 16'h0000;
    @(negedge clk);
    if (race) begin
      tx_dat   = race_byte;
      tx_valid = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic host(input logic rnw, input logic [1:0] off, input logic [7:0] wd, output logic [7:0] rd);
    host_cycle(rnw, off, wd, 1'b0, 8'h00, rd);
  endtask

  task automatic local_push(input logic [7:0] b);
    @(negedge clk);
    tx_dat   = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic local_pop();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic model_host(input logic rnw, input logic [1:0] off, input logic [7:0] wd, output logic [7:0] exp);
    exp = 8'h00;
    if (!rnw) begin
      if (off == 2'd0) begin
        if (m_rx.size() < DEPTH) m_rx.push_back(wd);
        else m_ovf = 1'b1;
      end else if (off == 2'd2) begin
        m_irq = wd[0];
        if (wd[1]) begin
          m_rx.delete();
          m_tx.delete();
          m_unf = 1'b0;
          m_ovf = 1'b0;
        end
      end
    end else begin
      case (off)
        2'd0: if (m_tx.size() > 0) exp = m_tx.pop_front(); else m_unf = 1'b1;
        2'd1: begin
          exp = {m_tx.size() > 0, m_rx.size() == DEPTH, m_unf, m_ovf, 4'(m_rx.size())};
          m_unf = 1'b0;
          m_ovf = 1'b0;
        end
        2'd2: exp = {7'd0, m_irq};
        default: exp = 8'(m_tx.size());
      endcase
    end
  endtask

  task automatic chk_local(input string tag);
    chk({tag, " rx_valid"}, {7'd0, rx_valid}, {7'd0, m_rx.size() > 0});
    chk({tag, " rx_dat"}, rx_dat, (m_rx.size() > 0) ? m_rx[0] : 8'h00);
    chk({tag, " tx_ready"}, {7'd0, tx_ready}, {7'd0, m_tx.size() < DEPTH});
    chk({tag, " irqb"}, {7'd0, irqb}, {7'd0, !(m_irq && m_tx.size() > 0)});
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] exp;
    int r;

    resetb   = 1'b0;
    bbc_phi2 = 1'b0;
    bbc_adr  = 16'h0000;
    bbc_rnw  = 1'b1;
    host_drv = 1'b0;
    host_wd  = 8'h00;
    rx_ready = 1'b0;
    tx_dat   = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (3) @(negedge clk);

    chk("reset rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("reset rx_dat", rx_dat, 8'h00);
    chk("reset tx_ready", {7'd0, tx_ready}, 8'h01);
    chk("reset irqb", {7'd0, irqb}, 8'h01);
    chk("reset bbc_data released", bbc_data, 8'hFF);

    tbl[0]  = '{1'b1, 2'd1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[1]  = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{1'b1, 2'd2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 2'd0, 8'hA5, 8'h00, 1'b1, 8'hA5, 1'b1};
    tbl[4]  = '{1'b1, 2'd1, 8'h00, 8'h01, 1'b1, 8'hA5, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 8'h5A, 8'h00, 1'b1, 8'hA5, 1'b1};
    tbl[6]  = '{1'b1, 2'd1, 8'h00, 8'h02, 1'b1, 8'hA5, 1'b1};
    tbl[7]  = '{1'b0, 2'd2, 8'h03, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[8]  = '{1'b1, 2'd2, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[9]  = '{1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 2'd1, 8'h00, 8'h20, 1'b0, 8'h00, 1'b1};
    tbl[11] = '{1'b1, 2'd1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1};

    for (int i = 0; i < 12; i++) begin
      host(tbl[i].rnw, tbl[i].off, tbl[i].wd, rd);
      if (tbl[i].rnw) chk($sformatf("tbl%0d rd", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d rx_valid", i), {7'd0, rx_valid}, {7'd0, tbl[i].rxv});
      chk($sformatf("tbl%0d rx_dat", i), rx_dat, tbl[i].rxd);
      chk($sformatf("tbl%0d irqb", i), {7'd0, irqb}, {7'd0, tbl[i].irq});
    end

    // TX order, underflow and irq with irq_en left set by the table
    local_push(8'h11);
    chk("irq after push", {7'd0, irqb}, 8'h00);
    local_push(8'h22);
    host(1'b1, 2'd0, 8'h00, rd);
    chk("tx read 1", rd, 8'h11);
    chk("irq one left", {7'd0, irqb}, 8'h00);
    host(1'b1, 2'd0, 8'h00, rd);
    chk("tx read 2", rd, 8'h22);
    chk("irq after drain", {7'd0, irqb}, 8'h01);
    host(1'b1, 2'd0, 8'h00, rd);
    chk("tx read empty", rd, 8'h00);
    host(1'b1, 2'd1, 8'h00, rd);
    chk("status underflow", rd, 8'h20);
    host(1'b1, 2'd1, 8'h00, rd);
    chk("status cleared", rd, 8'h00);
    host(1'b0, 2'd2, 8'h00, rd);

    // RX overflow at DEPTH
    for (int i = 1; i <= 9; i++) host(1'b0, 2'd0, 8'(i), rd);
    host(1'b1, 2'd1, 8'h00, rd);
    chk("status rx full ovf", rd, 8'h58);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain %0d", i), rx_dat, 8'(i));
      local_pop();
    end
    chk("drained rx_valid", {7'd0, rx_valid}, 8'h00);
    host(1'b1, 2'd1, 8'h00, rd);
    chk("status after drain", rd, 8'h00);

    // flush event coincides with a local tx push
    local_push(8'h77);
    host(1'b1, 2'd3, 8'h00, rd);
    chk("txcnt before flush", rd, 8'h01);
    host_cycle(1'b0, 2'd2, 8'h02, 1'b1, 8'h88, rd);
    host(1'b1, 2'd3, 8'h00, rd);
    chk("txcnt after flush race", rd, 8'h00);
    chk("tx_ready after flush", {7'd0, tx_ready}, 8'h01);

    // reset in the middle of a host DATA read
    local_push(8'h3C);
    host(1'b0, 2'd0, 8'h44, rd);
    bbc_adr = BASE;
    bbc_rnw = 1'b1;
    repeat (8) @(negedge clk);
    bbc_phi2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("read driven before reset", bbc_data, 8'h3C);
    #5 resetb = 1'b0;
    #1;
    chk("bus released in reset", bbc_data, 8'hFF);
    chk("rx_valid in reset", {7'd0, rx_valid}, 8'h00);
    chk("tx_ready in reset", {7'd0, tx_ready}, 8'h01);
    repeat (2) @(negedge clk);
    bbc_phi2 = 1'b0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    repeat (2) @(negedge clk);
    host(1'b1, 2'd3, 8'h00, rd);
    chk("txcnt after reset", rd, 8'h00);
    host(1'b1, 2'd1, 8'h00, rd);
    chk("status after reset", rd, 8'h00);

    // randomized traffic against the queue model
    m_rx.delete();
    m_tx.delete();
    m_unf = 1'b0;
    m_ovf = 1'b0;
    m_irq = 1'b0;
    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        logic [7:0] b;
        b = 8'($urandom);
        model_host(1'b0, 2'd0, b, exp);
        host(1'b0, 2'd0, b, rd);
      end else if (r < 66) begin
        logic [1:0] o;
        o = (r < 45) ? 2'd0 : (r < 55) ? 2'd1 : (r < 60) ? 2'd3 : 2'd2;
        model_host(1'b1, o, 8'h00, exp);
        host(1'b1, o, 8'h00, rd);
        chk($sformatf("rand %0d read off %0d", n, o), rd, exp);
      end else if (r < 70) begin
        logic [7:0] w;
        w = (r == 69) ? 8'h03 : {7'd0, 1'($urandom)};
        model_host(1'b0, 2'd2, w, exp);
        host(1'b0, 2'd2, w, rd);
      end else if (r < 88) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (m_tx.size() < DEPTH) m_tx.push_back(b);
        local_push(b);
      end else begin
        if (m_rx.size() > 0) void'(m_rx.pop_front());
        local_pop();
      end
      chk_local($sformatf("rand %0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bbc_mailbox_m.md
# bbc_mailbox_m

BBC-bus responder giving the host 6502 a byte mailbox in FRED space, the other end of the host-bus traffic our level-1b CPLD initiates. Host writes to DATA push into an RX FIFO drained by local logic over valid/ready. Local logic pushes into a TX FIFO that host DATA reads pop. A status register, sticky error flags and an open-drain IRQ complete the block, which sits beside the CPU-side glue on the same board.

## Interface
- BASE_ADR, 16'hFC40: host address of register 0; block decodes BASE_ADR..BASE_ADR+3.
- DEPTH, 8: entries per FIFO; legal values 2, 4, 8.
- clk  in  1  local clock, ≥24 MHz, asynchronous to bbc_phi2.
- resetb  in  1  reset, asynchronous, active-low.
- bbc_phi2  in  1  host phase-2 clock.
- bbc_adr  in  16  host address.
- bbc_rnw  in  1  host read/not-write.
- bbc_data  inout  8  host data bus.
- irqb  inout  1  open-drain host IRQ, driven low or Z.
- rx_dat  out  8  head of RX FIFO.
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  local pop of RX.
- tx_dat  in  8  byte to push into TX.
- tx_valid  in  1  local push request.
- tx_ready  out  1  TX FIFO not full.

## Operation
- Registers, offset from BASE_ADR:
  - +0 DATA. Write pushes to RX. Read returns the TX head and pops it.
  - +1 STATUS, read-only: [7] tx non-empty, [6] rx full, [5] tx underflow (sticky), [4] rx overflow (sticky), [3:0] rx count.
  - +2 CTRL: [0] irq_en, read/write. [1] flush, write-only, reads 0.
  - +3 TXCNT, read-only: [3:0] tx count.
- Host side:
  - Decode sel = (bbc_adr[15:2] == BASE_ADR[15:2]) is combinational.
  - bbc_data is driven only while bbc_phi2 & sel & bbc_rnw; otherwise Z.
  - Transparent-high latches on bbc_phi2 capture bbc_data, sel, offset and rnw. They close on the phi2 falling edge.
  - All host-side state change happens on the clk cycle that detects the phi2 falling edge (event cycle), using the latched values.
- DATA read with TX empty: returns 8'h00, no pop, sets underflow.
- DATA write with RX full: byte dropped, sets overflow.
- Every DATA read cycle pops, including 6502 dummy reads. Software must avoid indexed page-crossing access to DATA.
- STATUS read clears both sticky flags at the event cycle. The value returned is pre-clear.
- A flush write empties both FIFOs and clears the sticky flags. Flush beats a local tx push or rx pop in the same clk; those are discarded.
- Local side:
  - tx push occurs when tx_valid & tx_ready.
  - rx pop occurs when rx_valid & rx_ready.
  - Host and local operations on one FIFO in the same clk both take effect; count is unchanged when both happen.
- irqb is driven low while irq_en & tx non-empty; otherwise Z.
- Reset values:
  - FIFOs empty, counts 0, sticky flags 0, irq_en 0.
  - rx_valid 0, tx_ready 1, bbc_data Z, irqb Z.
  - rx_dat reads 8'h00.
- Reset asserted mid-cycle: bus released immediately and all state cleared. A host access in flight is lost.

## Timing
- bbc_phi2 goes through a 2-flop synchronizer plus an edge register. The event cycle is the 3rd clk rising edge after phi2 falls.
- RX push is visible on rx_valid one clk after the event cycle.
- A TX pop updates the head one clk after the event cycle. This is within 4 clk (≤167 ns at 24 MHz), before the next phi2 rise (≥250 ns at 2 MHz host). bbc_data is therefore stable through phi2.
- A local tx push into an empty FIFO is readable by a host cycle whose phi2 rises ≥1 clk after the push.
- Pointers are log2(DEPTH)+1 bits with a wrap bit; full = pointer MSBs differ & rest equal. Counts are 4-bit, range 0..DEPTH.
- phi2 pulses shorter than 3 clk are unsupported.

## Structure
- Package bbc_mbox_pkg holds:
  - register offset constants (REG_DATA=0, REG_STATUS=1, REG_CTRL=2, REG_TXCNT=3);
  - STATUS/CTRL bit indices;
  - the legal-DEPTH check.
- Sub-module sync_fifo_m (parameters WIDTH, DEPTH; push, pop, flush, count, full, empty) is instantiated twice, for RX and TX.
- The host latches, synchronizer, decode and register file live in the top module.

## Test plan
- Reset, then one host write 8'hA5 to FC40 → rx_valid=1 with rx_dat=A5 by the 4th clk after phi2 fall; STATUS reads 8'h01.
- Local pushes 11,22 then host reads FC40 twice → returns 11 then 22; third read returns 00, STATUS bit5=1, and the next STATUS read shows bit5=0.
- 9 host writes with DEPTH=8 and rx_ready=0 → STATUS=8'h58 (full, overflow, count 8); draining yields bytes 1..8, and the 9th is lost.
- CTRL write 8'h01 with TX empty → irqb Z; local push → irqb low; host pop → irqb Z.
- Local tx push in the same clk as the host flush event → TXCNT reads 0 and tx_ready=1.
- resetb low during phi2 of a host DATA read → bbc_data Z immediately, all counts 0, rx_valid 0.
